gpio_bank_arbiter: RTL

- Shares the 20-pin user GPIO bank (mprj_io[19:0] path) among NREQ internal peripheral requesters inside the user project.
- Grants the pads round-robin and registers the owner's output and output-enable onto the pads.
- Inserts a high-Z turnaround window between owners so two requesters never drive the pads back-to-back.
- Sits between the peripheral-extender cores and the user project's io_out/io_oeb pad buses.

---
 rtl/gpio_arb_pkg.sv | 26 ++
 rtl/gpio_arb_rr_pick.sv | 42 ++++
 rtl/gpio_bank_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gpio_arb_pkg.sv
// ============================================================================
// Module : gpio_arb_pkg
// Shared types, default sizes and width helper for the GPIO bank arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gpio_arb_pkg;

    localparam int c_GPIO_W_DFLT = 20;
    localparam int c_NREQ_DFLT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_arb_rr_pick.sv
// ============================================================================
// Module : gpio_arb_rr_pick
// Combinational round-robin picker: first set request at or after the pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_arb_rr_pick
    import gpio_arb_pkg::*;
#(
    parameter int NREQ = c_NREQ_DFLT
) (
    input  logic [NREQ-1:0]        i_req,
    input  logic [idx_w(NREQ)-1:0] i_ptr,
    output logic                   o_valid,
    output logic [idx_w(NREQ)-1:0] o_idx
);

    localparam int IW = idx_w(NREQ);

    logic [31:0] w_cand;

    // Walk from farthest to nearest so the candidate closest to the pointer wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = 32'(i_ptr) + 32'(k);
            if (w_cand >= 32'(NREQ)) begin
                w_cand = w_cand - 32'(NREQ);
            end
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpio_bank_arbiter.sv
// ============================================================================
// Module : gpio_bank_arbiter
// Round-robin owner of the user GPIO pad bank with a high-Z turnaround gap.
// Optional forced release on long holds: define GPIO_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_bank_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NREQ     = c_NREQ_DFLT,
    parameter int GPIO_W   = c_GPIO_W_DFLT,
    parameter int TURN_CYC = 2,
    parameter int HOLD_MAX = 1024
) (
    input  logic                   wb_clk_i,
    input  logic                   resetb,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*GPIO_W-1:0] req_out_i,
    input  logic [NREQ*GPIO_W-1:0] req_oeb_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [GPIO_W-1:0]      io_out,
    output logic [GPIO_W-1:0]      io_oeb,
    output logic                   busy_o,
    output logic [idx_w(NREQ)-1:0] last_owner_o,
    output logic                   timeout_o
);

    localparam int IW = idx_w(NREQ);
    localparam int TW = idx_w(TURN_CYC + 1);
    localparam logic [TW-1:0] c_TURN_LAST = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam logic [IW-1:0] c_OWNER_MAX = IW'(NREQ - 1);

    arb_state_t        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_owner;
    logic [NREQ-1:0]   r_gnt;
    logic [GPIO_W-1:0] r_io_out;
    logic [GPIO_W-1:0] r_io_oeb;
    logic              r_busy;
    logic [IW-1:0]     r_last_owner;
    logic [TW-1:0]     r_turn_cnt;

    logic              w_pick_vld;
    logic [IW-1:0]     w_pick_idx;
    logic              w_owner_req;
    logic              w_force;
    logic [IW-1:0]     w_ptr_next;
    logic [GPIO_W-1:0] w_out_slice [NREQ];
    logic [GPIO_W-1:0] w_oeb_slice [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign w_out_slice[k] = req_out_i[k*GPIO_W +: GPIO_W];
        assign w_oeb_slice[k] = req_oeb_i[k*GPIO_W +: GPIO_W];
    end

    gpio_arb_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    assign w_owner_req = req_i[r_owner];
    assign w_ptr_next  = (r_owner == c_OWNER_MAX) ? '0 : r_owner + IW'(1);

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int HW = idx_w(HOLD_MAX + 1);
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(HOLD_MAX - 1);

    logic [HW-1:0] r_hold_cnt;
    logic          r_timeout;
    logic          w_others;

    assign w_others  = |(req_i & ~r_gnt);
    assign w_force   = (r_hold_cnt == c_HOLD_LAST) && w_others;
    assign timeout_o = r_timeout;
`else
    assign w_force   = 1'b0;
    // HOLD_MAX only has an effect in the timeout build.
    assign timeout_o = 1'b0 & (HOLD_MAX > 0);
`endif

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_gnt        <= '0;
            r_io_out     <= '0;
            r_io_oeb     <= '1;
            r_busy       <= 1'b0;
            r_last_owner <= '0;
            r_turn_cnt   <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
            r_hold_cnt   <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
`ifdef GPIO_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_pick_idx;
                        r_gnt   <= NREQ'(1) << w_pick_idx;
                        r_busy  <= 1'b1;
`ifdef GPIO_ARB_TIMEOUT_EN
                        r_hold_cnt <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req || w_force) begin
                        r_gnt        <= '0;
                        r_io_out     <= '0;
                        r_io_oeb     <= '1;
                        r_last_owner <= r_owner;
                        r_ptr        <= w_ptr_next;
                        r_turn_cnt   <= '0;
                        if (TURN_CYC == 0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_TURN;
                        end
`ifdef GPIO_ARB_TIMEOUT_EN
                        // Only a release forced while the owner still requests is a timeout.
                        r_timeout <= w_force && w_owner_req;
`endif
                    end else begin
                        r_io_out <= w_out_slice[r_owner];
                        r_io_oeb <= w_oeb_slice[r_owner];
`ifdef GPIO_ARB_TIMEOUT_EN
                        if (r_hold_cnt != c_HOLD_LAST) begin
                            r_hold_cnt <= r_hold_cnt + HW'(1);
                        end
`endif
                    end
                end
                ST_TURN: begin
                    if (r_turn_cnt == c_TURN_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_gnt   <= '0;
                    r_io_oeb <= '1;
                end
            endcase
        end
    end

    assign gnt_o        = r_gnt;
    assign io_out       = r_io_out;
    assign io_oeb       = r_io_oeb;
    assign busy_o       = r_busy;
    assign last_owner_o = r_last_owner;

endmodule

`default_nettype wire
